hazard_fwd_ctrl: RTL
====================

Name: hazard_fwd_ctrl

Overview:
Backward-flowing control block for the 5-stage pipeline. Pipeline registers carry instructions forward; this block returns stall, flush and forwarding decisions to the IF/ID, ID/EX and EX/MEM registers. It keeps its own shadow scoreboard of the destination register, RegWrite and MemRead bits for the instructions in EX, MEM and WB. From that scoreboard it detects load-use hazards, resolves forwarding selects one cycle ahead, squashes wrong-path instructions on redirect, and freezes everything while data memory is busy.

Parameters:
REG_W, 5, register-index width
CNT_W, 16, width of the saturating performance counters

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
reset  in  1  synchronous, active-low; sampled on rising edge of clk
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_W  rs field of the ID instruction
id_rt  in  REG_W  rt field of the ID instruction
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_regwrite  in  1  ID instruction writes a register
id_memread  in  1  ID instruction is a load
id_wr_reg  in  REG_W  ID destination register (already muxed rd/rt/31)
ex_redirect  in  1  branch taken or jump resolved in EX this cycle
mem_ready  in  1  data memory access completes this cycle (1 when no access)
pc_hold  out  1  hold PC and IF/ID
freeze_all  out  1  hold ID/EX, EX/MEM, MEM/WB (memory wait)
bubble_idex  out  1  load zero control into ID/EX
flush_ifid  out  1  load zero into IF/ID
fwd_a  out  2  EX operand A select: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB write data
fwd_b  out  2  same, for operand B
stall_cnt  out  CNT_W  load-use stall cycles, saturating
flush_cnt  out  CNT_W  redirect events, saturating

Behaviour:
- Scoreboard: three entries, S_EX, S_MEM and S_WB. Each entry is {v, wr, ld, rd}. An entry "matches" register r when v & wr & rd!=0 & rd==r.
- Load-use hazard (combinational): lu = id_valid & S_EX.v & S_EX.ld & S_EX.wr & S_EX.rd!=0 & ((id_uses_rs & id_rs==S_EX.rd) | (id_uses_rt & id_rt==S_EX.rd)).
- Output equations, all combinational:
  - freeze_all = ~mem_ready.
  - pc_hold = freeze_all | (lu & ~ex_redirect).
  - flush_ifid = ex_redirect & mem_ready.
  - bubble_idex = mem_ready & (ex_redirect | lu).
- Priority: freeze > redirect > load-use. A redirect cancels a simultaneous load-use stall because the ID instruction is wrong-path.
- Per-edge update when reset=1:
  - freeze_all=1: the scoreboard, fwd_a/fwd_b and the counters hold.
  - Otherwise the scoreboard shifts: S_WB<=S_MEM, S_MEM<=S_EX.
  - S_EX <= empty (v=0) if bubble_idex, else {id_valid, id_regwrite, id_memread, id_wr_reg}.
- Forwarding selects are registered, so they align with the instruction entering EX:
  - fwd_a <= 01 if id_uses_rs & S_EX matches id_rs.
  - Else fwd_a <= 10 if id_uses_rs & S_MEM matches id_rs.
  - Else fwd_a <= 00. fwd_b is the same using id_rt.
  - EX-stage match wins over MEM-stage match (newest value).
  - When bubble_idex, fwd_a and fwd_b <= 00.
  - S_WB to ID is covered by register-file write-first bypass, so no select is generated for it.
  - A non-load match on S_EX never stalls. A load match on S_MEM yields 10 after the one-cycle stall.
- Counters:
  - stall_cnt increments on each non-frozen edge with lu & ~ex_redirect.
  - flush_cnt increments on each non-frozen edge with ex_redirect.
  - Both saturate at all-ones with no wrap.
- Register 0 never matches: no stall and no forwarding for $zero.
- Reset: on a rising edge with reset=0, all scoreboard v<=0, fwd_a=fwd_b=00, stall_cnt=flush_cnt=0. This applies regardless of mem_ready or any mid-stall or mid-freeze state.
- Combinational outputs after reset follow from the empty scoreboard: pc_hold=0 and bubble_idex=0 unless ex_redirect or ~mem_ready.

Test Plan:
- Reset: hold reset=0 for 2 clocks with random inputs. Required: fwd_a=fwd_b=00, stall_cnt=flush_cnt=0; with id_valid=0, mem_ready=1, ex_redirect=0, all stall and flush outputs are 0.
- Back-to-back ALU: add $3 (wr=1, rd=3), then sub using rs=3. Required: fwd_a=01 on the sub's EX cycle; next, an instruction using rt=3 two slots later gets fwd_b=10; rs=0 with rd=0 gives 00.
- Load-use: lw $5 then add using rs=5. Required: exactly one cycle of pc_hold=1 and bubble_idex=1, stall_cnt=1, and fwd_a=10 when the add enters EX.
- Redirect during load-use: the same cycle as lu=1, assert ex_redirect. Required: pc_hold=0, flush_ifid=1, bubble_idex=1, flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_ready=0 for 3 cycles with a dependent instruction pending. Required: freeze_all=pc_hold=1, bubble_idex=0, scoreboard, fwd_* and counters unchanged; after release, forwarding resumes exactly as without the wait.
- Saturation and mid-op reset: with CNT_W=4 force 20 load-use stalls, then check stall_cnt=15. Assert reset=0 during a freeze. Required: all state cleared on that edge.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - pipeline hazard detection, stall/flush and forwarding control
// Holds a shadow scoreboard of EX and MEM destinations and returns stall/flush/forward decisions.
module hazard_fwd_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             ex_redirect,
  input  logic             mem_ready,
  output logic             pc_hold,
  output logic             freeze_all,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The WB entry is never consulted (register-file write-first bypass covers it), so only EX and MEM are kept.
  logic             ex_v_q, ex_v_d;
  logic             ex_wr_q, ex_wr_d;
  logic             ex_ld_q, ex_ld_d;
  logic [REG_W-1:0] ex_rd_q, ex_rd_d;
  logic             mem_v_q, mem_v_d;
  logic             mem_wr_q, mem_wr_d;
  logic [REG_W-1:0] mem_rd_q, mem_rd_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;

  function automatic logic hit(input logic v, input logic wr,
                               input logic [REG_W-1:0] rd, input logic [REG_W-1:0] r);
    return v & wr & (rd != '0) & (rd == r);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic use_r, input logic ex_hit, input logic mem_hit);
    if (use_r & ex_hit)  return 2'b01;
    if (use_r & mem_hit) return 2'b10;
    return 2'b00;
  endfunction

  assign lu = id_valid & ex_ld_q &
              ((id_uses_rs & hit(ex_v_q, ex_wr_q, ex_rd_q, id_rs)) |
               (id_uses_rt & hit(ex_v_q, ex_wr_q, ex_rd_q, id_rt)));

  assign freeze_all  = ~mem_ready;
  assign pc_hold     = freeze_all | (lu & ~ex_redirect);
  assign flush_ifid  = ex_redirect & mem_ready;
  assign bubble_idex = mem_ready & (ex_redirect | lu);
  assign fwd_a       = fwd_a_q;
  assign fwd_b       = fwd_b_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

  always_comb begin
    ex_v_d      = ex_v_q;
    ex_wr_d     = ex_wr_q;
    ex_ld_d     = ex_ld_q;
    ex_rd_d     = ex_rd_q;
    mem_v_d     = mem_v_q;
    mem_wr_d    = mem_wr_q;
    mem_rd_d    = mem_rd_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (mem_ready) begin
      mem_v_d  = ex_v_q;
      mem_wr_d = ex_wr_q;
      mem_rd_d = ex_rd_q;
      if (bubble_idex) begin
        ex_v_d  = 1'b0;
        ex_wr_d = 1'b0;
        ex_ld_d = 1'b0;
        ex_rd_d = '0;
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
      end else begin
        ex_v_d  = id_valid;
        ex_wr_d = id_regwrite;
        ex_ld_d = id_memread;
        ex_rd_d = id_wr_reg;
        // EX hit wins over MEM hit: it carries the newer value
        fwd_a_d = fwd_sel(id_uses_rs, hit(ex_v_q, ex_wr_q, ex_rd_q, id_rs),
                          hit(mem_v_q, mem_wr_q, mem_rd_q, id_rs));
        fwd_b_d = fwd_sel(id_uses_rt, hit(ex_v_q, ex_wr_q, ex_rd_q, id_rt),
                          hit(mem_v_q, mem_wr_q, mem_rd_q, id_rt));
      end
      if (lu & ~ex_redirect & (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (ex_redirect & (flush_cnt_q != '1))       flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_v_q      <= 1'b0;
      ex_wr_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      ex_rd_q     <= '0;
      mem_v_q     <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= '0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_v_q      <= ex_v_d;
      ex_wr_q     <= ex_wr_d;
      ex_ld_q     <= ex_ld_d;
      ex_rd_q     <= ex_rd_d;
      mem_v_q     <= mem_v_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
